// File: rtl/seq_scan_ctrl.sv
// Word-fed serial pattern detector: shifts each accepted word MSB first into a
// PAT_W history and counts matches. Optional threshold interrupt: SCAN_THRESH_EN.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap_en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
`ifdef SCAN_THRESH_EN
  input  logic [CNT_W-1:0]  thresh,
  output logic              thresh_irq,
`endif
  output logic              in_ready,
  output logic              bit_out,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        crnt_state
);

  localparam int BC_W   = $clog2(WORD_W + 1);
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   data_q;
  logic [PAT_W-1:0]    pat_q;
  logic                ovl_q;
  logic [BC_W-1:0]     bit_cnt;
  logic [PAT_W-1:0]    hist;
  logic [FILL_W-1:0]   fill;

  logic                shift_bit;
  logic [PAT_W-1:0]    hist_nxt;
  logic [FILL_W-1:0]   fill_inc;
  logic                hit;
  logic                last_bit;
  logic [CNT_W-1:0]    cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign crnt_state = state;
  assign shift_bit  = data_q[WORD_W-1];
  assign hist_nxt   = {hist[PAT_W-2:0], shift_bit};
  assign fill_inc   = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
  // The history is only trusted once PAT_W fresh bits have entered it.
  assign hit        = (fill_inc == FILL_W'(PAT_W)) && (hist_nxt == pat_q);
  assign last_bit   = (bit_cnt == BC_W'(WORD_W - 1));
  assign cnt_inc    = sat_inc(match_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_out     <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
      data_q      <= '0;
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      bit_cnt     <= '0;
      hist        <= '0;
      fill        <= '0;
`ifdef SCAN_THRESH_EN
      thresh_irq  <= 1'b0;
`endif
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
`ifdef SCAN_THRESH_EN
            thresh_irq  <= 1'b0;
`endif
          end
          if (in_valid) begin
            data_q   <= in_data;
            pat_q    <= pattern;
            ovl_q    <= overlap_en;
            bit_cnt  <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          data_q  <= data_q << 1;
          bit_out <= shift_bit;
          hist    <= hist_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (hit) begin
            match_pulse <= 1'b1;
            match_count <= cnt_inc;
            // Non-overlapping mode: old bits stay in hist but must be refilled.
            fill        <= ovl_q ? fill_inc : '0;
`ifdef SCAN_THRESH_EN
            if (thresh != '0 && cnt_inc >= thresh) thresh_irq <= 1'b1;
`endif
          end else begin
            fill <= fill_inc;
          end
          if (last_bit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed, table-driven bench for seq_scan_ctrl (WORD_W=8, PAT_W=4, CNT_W=8).
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] pattern;
  logic       overlap_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       bit_out;
  logic       match_pulse;
  logic [7:0] match_count;
  logic       busy;
  logic       done;
  logic [1:0] crnt_state;
`ifdef SCAN_THRESH_EN
  logic [7:0] thresh = 8'd2;
  logic       thresh_irq;
`endif

  int errs = 0;
  int checks = 0;

  seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .pattern(pattern),
    .overlap_en(overlap_en), .in_valid(in_valid), .in_data(in_data),
`ifdef SCAN_THRESH_EN
    .thresh(thresh), .thresh_irq(thresh_irq),
`endif
    .in_ready(in_ready), .bit_out(bit_out), .match_pulse(match_pulse),
    .match_count(match_count), .busy(busy), .done(done),
    .crnt_state(crnt_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [3:0] pat;
    logic       ovl;
    logic       clr;
    logic [7:0] exp_mask;   // bit k-1 set => match_pulse after SHIFT edge k
    int         exp_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one word, then records match_pulse and bit_out after each SHIFT edge.
  task automatic run_word(input logic [7:0] w, input logic [3:0] p, input logic o,
                          input logic c, output logic [7:0] pulses, output logic [7:0] bits);
    int n;
    pulses = '0;
    bits   = '0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; in_data = w; pattern = p; overlap_en = o; clr = c;
    @(posedge clk);
    #1;
    // Disturb the inputs while busy; the captured copies must be used.
    in_valid = 1'b0; clr = 1'b0; in_data = ~w; pattern = ~p; overlap_en = ~o;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      pulses[k-1] = match_pulse;
      bits[8-k]   = bit_out;
      if (k == 7) chk("done_early", 32'(done), 32'd0);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("state_done", 32'(crnt_state), 32'd2);
    @(posedge clk);
    #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("state_idle", 32'(crnt_state), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] m, b;
    int exp_cnt;

    tbl[0] = '{8'b11011010, 4'b1101, 1'b1, 1'b1, 8'h48, 2};
    tbl[1] = '{8'b11011010, 4'b1101, 1'b0, 1'b1, 8'h08, 1};
    tbl[2] = '{8'b00000110, 4'b1101, 1'b0, 1'b1, 8'h00, 0};
    tbl[3] = '{8'b10000000, 4'b1101, 1'b0, 1'b0, 8'h01, 1};
    tbl[4] = '{8'h00,       4'b0000, 1'b1, 1'b1, 8'hF8, 5};
    tbl[5] = '{8'h00,       4'b0000, 1'b0, 1'b1, 8'h88, 2};

    reset = 1'b1; clr = 1'b0; pattern = '0; overlap_en = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_state", 32'(crnt_state), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pulse", 32'(match_pulse), 32'd0);
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_word(tbl[i].word, tbl[i].pat, tbl[i].ovl, tbl[i].clr, m, b);
      chk($sformatf("vec%0d_pulses", i), 32'(m), 32'(tbl[i].exp_mask));
      chk($sformatf("vec%0d_bits", i), 32'(b), 32'(tbl[i].word));
      chk($sformatf("vec%0d_count", i), 32'(match_count), 32'(tbl[i].exp_cnt));
    end

    // Zero stream with overlap: the history stays full across words.
    exp_cnt = tbl[5].exp_cnt;
    for (int w = 0; w < 40; w++) begin
      logic [7:0] em;
      em = (w == 0) ? 8'hF8 : 8'hFF;
      run_word(8'h00, 4'b0000, 1'b1, 1'b0, m, b);
      exp_cnt = exp_cnt + $countones(em);
      if (exp_cnt > 255) exp_cnt = 255;
      chk($sformatf("sat%0d_pulses", w), 32'(m), 32'(em));
      chk($sformatf("sat%0d_count", w), 32'(match_count), 32'(exp_cnt));
    end

    // Clear alone in IDLE.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_only_count", 32'(match_count), 32'd0);

    run_word(8'b11011010, 4'b1101, 1'b1, 1'b0, m, b);
    chk("pre_abort_count", 32'(match_count), 32'd2);

    // Reset in the middle of a word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'b11011010; pattern = 4'b1101; overlap_en = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(crnt_state), 32'd0);
    chk("abort_count", 32'(match_count), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_idle", 32'(crnt_state), 32'd0);
    run_word(8'b11011010, 4'b1101, 1'b1, 1'b0, m, b);
    chk("post_abort_pulses", 32'(m), 32'h48);
    chk("post_abort_count", 32'(match_count), 32'd2);

`ifdef SCAN_THRESH_EN
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'b11011010; pattern = 4'b1101; overlap_en = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0; in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("irq_edge%0d", k), 32'(thresh_irq), (k >= 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    chk("irq_sticky", 32'(thresh_irq), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("irq_clr", 32'(thresh_irq), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
